// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl_pkg: shared typedefs and constants for the CPU run controller.
//   run_state_e  : controller FSM states
//   PH_W         : width of the CPU phase counter
//   PH_ALU_LATCH : phase count at which the ALU latch enable drops
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } run_state_e;

    localparam int          PH_W         = 4;
    localparam logic [3:0]  PH_ALU_LATCH = 4'hC;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: program-load handshake plus the CPU memory write port.
//   ld_valid/ld_ready/ld_addr/ld_data : load beats from the host
//   mem_we/mem_addr/mem_wdata         : write port into CPU program memory
//   master : host side (drives load beats, observes the write port)
//   slave  : controller side
interface cpu_run_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) ();
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output ld_valid, ld_addr, ld_data,
        input  ld_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  ld_valid, ld_addr, ld_data,
        output ld_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cpu_run_ctrl_phase_gen.sv
// cpu_phase_gen: 4-bit CPU phase counter and phase-enable decode.
//   clk, rst : clock, async active-high reset
//   en       : advance the counter this clock
//   clr      : synchronously clear the counter (wins over en)
//   ph_*     : phase enables decoded from the count
//   cyc_tick : this clock's advance makes cnt[1] rise, i.e. one CPU cycle
module cpu_phase_gen
    import cpu_run_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic ph_cntrl,
    output logic ph_clk,
    output logic ph_fetch,
    output logic ph_alu,
    output logic cyc_tick
);
    logic [PH_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + PH_W'(1);
    end

    assign ph_cntrl = ~cnt[0];
    assign ph_clk   = cnt[1];
    assign ph_fetch = ~cnt[3];
    assign ph_alu   = (cnt != PH_ALU_LATCH);
    // cnt[1] goes 0->1 exactly when an increment leaves cnt[1:0]==2'b01
    assign cyc_tick = en && (cnt[1:0] == 2'b01);
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: loads a program into CPU memory, holds the CPU in reset,
// runs it with generated phase enables and reports halt/timeout status.
//   clk, rst              : clock, async active-high reset
//   bus (slave)           : load handshake and memory write port
//   start, abort          : run request / forced return to IDLE
//   max_cycles, exp_pc    : timeout in CPU cycles, expected halt PC
//   cpu_rst_n, ph_*       : CPU reset and phase enables
//   cpu_halt, cpu_pc      : CPU status inputs
//   busy, done, pass, timeout, final_pc, cycles_used : run status
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int CYC_W   = 16,
    parameter int RST_CYC = 5
) (
    input  logic              clk,
    input  logic              rst,
    cpu_run_ctrl_if.slave     bus,
    input  logic              start,
    input  logic              abort,
    input  logic [CYC_W-1:0]  max_cycles,
    input  logic [ADDR_W-1:0] exp_pc,
    output logic              cpu_rst_n,
    output logic              ph_cntrl,
    output logic              ph_clk,
    output logic              ph_fetch,
    output logic              ph_alu,
    input  logic              cpu_halt,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [ADDR_W-1:0] final_pc,
    output logic [CYC_W-1:0]  cycles_used
);
    localparam int RC_W = $clog2(RST_CYC + 1);

    run_state_e      state, nxt;
    logic [RC_W-1:0] rst_cnt;
    logic            ld_fire, tmo_hit, run_stay, ph_clr, cyc_tick;

    assign bus.ld_ready = (state == ST_IDLE) || (state == ST_DONE);
    assign ld_fire      = bus.ld_valid && bus.ld_ready;
    assign busy         = (state == ST_RESET) || (state == ST_RUN);
    assign done         = (state == ST_DONE);
    assign cpu_rst_n    = (state == ST_RUN) || (state == ST_DONE);
    assign tmo_hit      = (cycles_used == max_cycles);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (abort) nxt = ST_IDLE;
        else begin
            case (state)
                ST_IDLE, ST_DONE: if (start) nxt = ST_RESET;
                ST_RESET: if (rst_cnt == RC_W'(RST_CYC - 1)) nxt = ST_RUN;
                ST_RUN:   if (cpu_halt || tmo_hit) nxt = ST_DONE;
                default:  nxt = ST_IDLE;
            endcase
        end
    end

    // Phase counter and cycle count advance only on clocks that stay in RUN,
    // so both freeze together on the clock that enters DONE.
    assign run_stay = (state == ST_RUN) && (nxt == ST_RUN);
    assign ph_clr   = (nxt == ST_IDLE) || (nxt == ST_RESET);

    cpu_phase_gen u_phase (
        .clk      (clk),
        .rst      (rst),
        .en       (run_stay),
        .clr      (ph_clr),
        .ph_cntrl (ph_cntrl),
        .ph_clk   (ph_clk),
        .ph_fetch (ph_fetch),
        .ph_alu   (ph_alu),
        .cyc_tick (cyc_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    rst_cnt <= '0;
        else if (state != ST_RESET) rst_cnt <= '0;
        else                        rst_cnt <= rst_cnt + RC_W'(1);
    end

    // Load beats land on the write port one clock later; abort drops the beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_we <= ld_fire && !abort;
            if (ld_fire) begin
                bus.mem_addr  <= bus.ld_addr;
                bus.mem_wdata <= bus.ld_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass        <= 1'b0;
            timeout     <= 1'b0;
            final_pc    <= '0;
            cycles_used <= '0;
        end else if (abort) begin
            // status holds; only busy/done drop via the state change
        end else if (bus.ld_ready && start) begin
            pass        <= 1'b0;
            timeout     <= 1'b0;
            cycles_used <= '0;
        end else if (state == ST_RUN) begin
            if (cpu_halt) begin
                final_pc <= cpu_pc;
                pass     <= (cpu_pc == exp_pc);
                timeout  <= 1'b0;
            end else if (tmo_hit) begin
                final_pc <= cpu_pc;
                pass     <= 1'b0;
                timeout  <= 1'b1;
            end else if (cyc_tick && (cycles_used != '1)) begin
                cycles_used <= cycles_used + CYC_W'(1);
            end
        end
    end
endmodule
